instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
Fetch/execute sequencer for the calculator CPU. It owns the program counter, fetches 16-bit instructions from instruction memory and presents them to the decoder. It commits next-PC from the decoder's bra/jmp/psh/pop/jmp_addr outputs, maintains the call/return stack, and stalls on multi-cycle ALU ops (MUL/DIV/MOD) via a start/done handshake.

Parameters:
PC_W, 10, program counter / instruction address width
STACK_DEPTH, 4, return-stack entries (power of 2, >=2)
ALU_TIMEOUT, 64, max cycles to wait for alu_done before error

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous active-low reset
imem_addr  output  PC_W  instruction memory address (= pc)
imem_rd  output  1  instruction memory read strobe; data valid next cycle
imem_data  input  16  instruction word from memory
instr  output  16  registered instruction to decoder
bra  input  1  decoder: take branch
jmp  input  1  decoder: call/return class
psh  input  1  decoder: push return address (call)
pop  input  1  decoder: pop return address (RET)
jmp_addr  input  PC_W  decoder branch/call target
alu_start  output  1  one-cycle pulse starting a multi-cycle ALU op
alu_done  input  1  ALU result ready
exec_en  output  1  one-cycle commit strobe (register/ACC/flag write enable)
pc  output  PC_W  current program counter
halted  output  1  sequencer in HALT
err  output  2  00 none, 01 stack overflow, 10 stack underflow, 11 ALU timeout

Behaviour:
- Reset (reset==0 at clk edge): pc=0, sp=0, instr=0, state=FETCH, err=00, halted=0, wait counter=0. While reset is low, imem_rd, alu_start, exec_en are forced 0. Reset mid-operation (any state, incl. WAIT_ALU) aborts immediately; no commit.
- States: FETCH, DECODE, EXEC, WAIT_ALU, HALT.
- FETCH: imem_rd=1, imem_addr=pc -> DECODE.
- DECODE: instr <= imem_data -> EXEC.
- EXEC: decoder outputs valid (combinational from instr). Opcode instr[15:10] in {010000 MUL, 010001 DIV, 010010 MOD}: alu_start=1 for this cycle, clear wait counter -> WAIT_ALU. Opcode 111111: -> HALT, no commit. Otherwise commit -> FETCH.
- WAIT_ALU: alu_done sampled only here (a done asserted in the EXEC cycle is ignored). alu_done=1 -> commit -> FETCH. Else counter++; counter reaching ALU_TIMEOUT -> err=11, HALT.
- Commit (single cycle, exec_en=1), priority order:
  1. pop=1: sp==0 -> err=10, HALT, exec_en=0; else pc <= stack[sp-1], sp--.
  2. psh=1 & jmp=1: sp==STACK_DEPTH -> err=01, HALT, exec_en=0; else stack[sp] <= pc+1, sp++, pc <= jmp_addr.
  3. bra=1: pc <= jmp_addr.
  4. else pc <= pc+1.
- PC arithmetic modulo 2^PC_W: pc=all-ones increments to 0; pushed return address wraps identically.
- HALT: halted=1, all strobes 0, pc/instr/stack frozen; exit only by reset. err holds its value.
- Latency: 3 cycles per single-cycle instruction; MUL/DIV/MOD take 3 + N cycles, where alu_done arrives N cycles after alu_start (N>=1).
- alu_done while not in WAIT_ALU is ignored.

Decomposition:
- Shared package (cpu_pkg): opcode constants (OP_MUL, OP_DIV, OP_MOD, OP_HALT, branch/JMP/RET codes), state encoding, err codes.
- One sub-module: ret_stack (STACK_DEPTH x PC_W LIFO with push/pop, full/empty, sp), instantiated once.

Test Plan:
- Reset, then memory holds ADD at 0..2 -> imem_addr 0,1,2 fetched every 3 cycles; exec_en pulses at cycles 3,6,9; pc=3.
- BRA to 0x200 at addr 5 -> next fetch address 0x200; sp unchanged.
- JMP 0x100 at addr 0x010, RET at 0x100 -> after call sp=1, stack[0]=0x011; after RET pc=0x011, sp=0.
- Five nested calls with STACK_DEPTH=4 -> fifth call gives err=01, halted=1, pc stays at the calling address, no exec_en.
- MUL at addr 7 with alu_done 5 cycles after alu_start -> exactly one alu_start pulse, exec_en one cycle after done is sampled, pc=8; with done withheld for 64 cycles -> err=11, HALT.
- RET with empty stack -> err=10; then reset pulled low during HALT -> pc=0, err=00, fetch resumes at 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the calculator CPU: opcodes, sequencer state encoding
// and error codes.
package cpu_pkg;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_MUL  = 6'b010000;
  localparam logic [5:0] OP_DIV  = 6'b010001;
  localparam logic [5:0] OP_MOD  = 6'b010010;
  localparam logic [5:0] OP_BRA  = 6'b100000;
  localparam logic [5:0] OP_JMP  = 6'b100001;
  localparam logic [5:0] OP_RET  = 6'b100010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [2:0] {
    ST_FETCH    = 3'd0,
    ST_DECODE   = 3'd1,
    ST_EXEC     = 3'd2,
    ST_WAIT_ALU = 3'd3,
    ST_HALT     = 3'd4
  } seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'b00,
    ERR_OVF    = 2'b01,
    ERR_UNF    = 2'b10,
    ERR_ALU_TO = 2'b11
  } err_t;

  function automatic logic is_multicycle(input logic [5:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO for call/return. sp counts occupied entries (0..DEPTH);
// top is the most recently pushed address.
module ret_stack
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 10,
  parameter int SP_W  = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [W-1:0]    push_data,
  output logic [W-1:0]    top,
  output logic [SP_W-1:0] sp,
  output logic            full,
  output logic            empty
);

  localparam int IDX_W = SP_W - 1;

  logic [W-1:0]    mem [DEPTH];
  logic [SP_W-1:0] sp_dec;

  assign sp_dec = sp - 1'b1;
  assign top    = mem[sp_dec[IDX_W-1:0]];
  assign full   = (sp == SP_W'(DEPTH));
  assign empty  = (sp == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp_dec;
    end
  end

  // Entries need no reset: sp alone decides which are meaningful.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[sp[IDX_W-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer: owns the PC, fetches instructions, commits
// next-PC from decoder outputs, manages the return stack and stalls on ALU ops.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W        = 10,
  parameter int STACK_DEPTH = 4,
  parameter int ALU_TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic [PC_W-1:0]              imem_addr,
  output logic                         imem_rd,
  input  logic [15:0]                  imem_data,
  output logic [15:0]                  instr,
  input  logic                         bra,
  input  logic                         jmp,
  input  logic                         psh,
  input  logic                         pop,
  input  logic [PC_W-1:0]              jmp_addr,
  output logic                         alu_start,
  input  logic                         alu_done,
  output logic                         exec_en,
  output logic [PC_W-1:0]              pc,
  output logic                         halted,
  output logic [1:0]                   err,
  output logic [2:0]                   dbg_state,
  output logic [$clog2(STACK_DEPTH):0] dbg_sp
);

  localparam int CNT_W = $clog2(ALU_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_TIMEOUT - 1);

  seq_state_t       state, state_nx;
  logic [PC_W-1:0]  pc_nx, pc_inc, stk_top;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nx;
  logic [1:0]       err_nx;
  logic             commit_req, rd_c, start_c, exec_c, do_push, do_pop;
  logic             stk_full, stk_empty;

  assign pc_inc = pc + 1'b1;

  ret_stack #(.DEPTH(STACK_DEPTH), .W(PC_W)) u_ret_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (do_push & reset),
    .pop       (do_pop & reset),
    .push_data (pc_inc),
    .top       (stk_top),
    .sp        (dbg_sp),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_FETCH;
      pc       <= '0;
      instr    <= '0;
      wait_cnt <= '0;
      err      <= ERR_NONE;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      wait_cnt <= wait_cnt_nx;
      err      <= err_nx;
      if (state == ST_DECODE) instr <= imem_data;
    end
  end

  // ALU handshake: alu_start pulses for the single EXEC cycle; alu_done is
  // only honoured in WAIT_ALU, where it commits in the same cycle it is seen.
  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    wait_cnt_nx = wait_cnt;
    err_nx      = err;
    commit_req  = 1'b0;
    rd_c        = 1'b0;
    start_c     = 1'b0;
    exec_c      = 1'b0;
    do_push     = 1'b0;
    do_pop      = 1'b0;
    case (state)
      ST_FETCH: begin
        rd_c     = 1'b1;
        state_nx = ST_DECODE;
      end
      ST_DECODE: state_nx = ST_EXEC;
      ST_EXEC: begin
        if (is_multicycle(instr[15:10])) begin
          start_c     = 1'b1;
          wait_cnt_nx = '0;
          state_nx    = ST_WAIT_ALU;
        end else if (instr[15:10] == OP_HALT) begin
          state_nx = ST_HALT;
        end else begin
          commit_req = 1'b1;
        end
      end
      ST_WAIT_ALU: begin
        if (alu_done) begin
          commit_req = 1'b1;
        end else if (wait_cnt == CNT_LAST) begin
          err_nx   = ERR_ALU_TO;
          state_nx = ST_HALT;
        end else begin
          wait_cnt_nx = wait_cnt + 1'b1;
        end
      end
      default: state_nx = ST_HALT;
    endcase

    // A stack fault replaces the commit: no strobe, PC stays on the faulting call/return.
    if (commit_req) begin
      state_nx = ST_FETCH;
      if (pop) begin
        if (stk_empty) begin
          err_nx   = ERR_UNF;
          state_nx = ST_HALT;
        end else begin
          pc_nx  = stk_top;
          do_pop = 1'b1;
          exec_c = 1'b1;
        end
      end else if (psh && jmp) begin
        if (stk_full) begin
          err_nx   = ERR_OVF;
          state_nx = ST_HALT;
        end else begin
          pc_nx   = jmp_addr;
          do_push = 1'b1;
          exec_c  = 1'b1;
        end
      end else if (bra) begin
        pc_nx  = jmp_addr;
        exec_c = 1'b1;
      end else begin
        pc_nx  = pc_inc;
        exec_c = 1'b1;
      end
    end
  end

  assign imem_addr = pc;
  assign imem_rd   = rd_c & reset;
  assign alu_start = start_c & reset;
  assign exec_en   = exec_c & reset;
  assign halted    = (state == ST_HALT);
  assign dbg_state = state;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: instruction memory and decoder models,
// an ALU responder, a vector table of single-instruction programs and
// hand-written multi-cycle sequences.
module tb_instr_sequencer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  imem_addr;
  logic        imem_rd;
  logic [15:0] imem_data = 16'h0000;
  logic [15:0] instr;
  logic        bra, jmp, psh, pop;
  logic [9:0]  jmp_addr;
  logic        alu_start;
  logic        alu_done;
  logic        exec_en;
  logic [9:0]  pc;
  logic        halted;
  logic [1:0]  err;
  logic [2:0]  dbg_state;
  logic [2:0]  dbg_sp;

  instr_sequencer #(.PC_W(10), .STACK_DEPTH(4), .ALU_TIMEOUT(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .imem_addr (imem_addr),
    .imem_rd   (imem_rd),
    .imem_data (imem_data),
    .instr     (instr),
    .bra       (bra),
    .jmp       (jmp),
    .psh       (psh),
    .pop       (pop),
    .jmp_addr  (jmp_addr),
    .alu_start (alu_start),
    .alu_done  (alu_done),
    .exec_en   (exec_en),
    .pc        (pc),
    .halted    (halted),
    .err       (err),
    .dbg_state (dbg_state),
    .dbg_sp    (dbg_sp)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory, decoder and ALU models ----------------
  logic [15:0] mem [1024];

  always @(posedge clk) begin
    if (imem_rd) imem_data <= mem[imem_addr];
  end

  always_comb begin
    bra      = (instr[15:10] == OP_BRA);
    psh      = (instr[15:10] == OP_JMP);
    pop      = (instr[15:10] == OP_RET);
    jmp      = psh || pop;
    jmp_addr = instr[9:0];
  end

  int alu_lat   = 0;    // 0: never answer
  bit alu_early = 1'b0; // answer only during the EXEC cycle
  int done_cnt  = 0;

  always @(negedge clk) begin
    alu_done = 1'b0;
    if (!reset) begin
      done_cnt = 0;
    end else begin
      if (done_cnt > 0) begin
        done_cnt = done_cnt - 1;
        if (done_cnt == 0) alu_done = 1'b1;
      end
      if (alu_start) begin
        if (alu_early) alu_done = 1'b1;
        else done_cnt = alu_lat;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          exec_cnt = 0;
  int          start_cnt = 0;
  logic [15:0] fetch_q[$];
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_fetch(input string name);
    check({name, "_nfetch"}, 32'(fetch_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < fetch_q.size()) check($sformatf("%s_fetch%0d", name, i), 32'(fetch_q[i]), 32'(exp_q[i]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic sample();
    if (imem_rd) fetch_q.push_back(16'(imem_addr));
    if (exec_en) exec_cnt++;
    if (alu_start) start_cnt++;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    cyc++;
    sample();
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
  endtask

  // Leaves the bench 1 time unit after the negedge of cycle 1 (first FETCH).
  task automatic do_reset(input string name);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check({name, "_rst_imem_rd"}, 32'(imem_rd), 0);
    check({name, "_rst_alu_start"}, 32'(alu_start), 0);
    check({name, "_rst_exec_en"}, 32'(exec_en), 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    cyc = 1;
    exec_cnt = 0;
    start_cnt = 0;
    fetch_q.delete();
    sample();
    check({name, "_rst_pc"}, 32'(pc), 0);
    check({name, "_rst_err"}, 32'(err), 0);
    check({name, "_rst_halted"}, 32'(halted), 0);
    check({name, "_rst_sp"}, 32'(dbg_sp), 0);
  endtask

  task automatic run_until_event(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      if (exec_en || halted) begin
        at = cyc;
        break;
      end
      tick();
    end
  endtask

  task automatic run_until_halt(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      if (halted) begin
        at = cyc;
        break;
      end
      tick();
    end
  endtask

  task automatic run_fetches(input int n, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (fetch_q.size() >= n) break;
      tick();
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [15:0] word;
    int          lat;
    int          exp_cyc;
    logic [9:0]  exp_pc;
    logic [1:0]  exp_err;
    logic        exp_halt;
    int          exp_start;
    logic [2:0]  exp_sp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int at;

    vecs[0] = '{"add",       16'h0000, 0, 3,  10'h001, 2'b00, 1'b0, 0, 3'd0};
    vecs[1] = '{"bra",       16'h8200, 0, 3,  10'h200, 2'b00, 1'b0, 0, 3'd0};
    vecs[2] = '{"jmp",       16'h8500, 0, 3,  10'h100, 2'b00, 1'b0, 0, 3'd1};
    vecs[3] = '{"mul5",      16'h4000, 5, 8,  10'h001, 2'b00, 1'b0, 1, 3'd0};
    vecs[4] = '{"div1",      16'h4400, 1, 4,  10'h001, 2'b00, 1'b0, 1, 3'd0};
    vecs[5] = '{"mod3",      16'h4800, 3, 6,  10'h001, 2'b00, 1'b0, 1, 3'd0};
    vecs[6] = '{"halt",      16'hFC00, 0, 4,  10'h000, 2'b00, 1'b1, 0, 3'd0};
    vecs[7] = '{"ret_empty", 16'h8800, 0, 4,  10'h000, 2'b10, 1'b1, 0, 3'd0};
    vecs[8] = '{"mul_to",    16'h4000, 0, 68, 10'h000, 2'b11, 1'b1, 1, 3'd0};

    foreach (vecs[k]) begin
      clear_mem();
      mem[0] = vecs[k].word;
      alu_lat = vecs[k].lat;
      alu_early = 1'b0;
      do_reset(vecs[k].name);
      run_until_event(200, at);
      check({vecs[k].name, "_cyc"}, 32'(at), 32'(vecs[k].exp_cyc));
      tick();
      check({vecs[k].name, "_pc"}, 32'(pc), 32'(vecs[k].exp_pc));
      check({vecs[k].name, "_err"}, 32'(err), 32'(vecs[k].exp_err));
      check({vecs[k].name, "_halted"}, 32'(halted), 32'(vecs[k].exp_halt));
      check({vecs[k].name, "_starts"}, 32'(start_cnt), 32'(vecs[k].exp_start));
      check({vecs[k].name, "_sp"}, 32'(dbg_sp), 32'(vecs[k].exp_sp));
    end

    // Straight-line ADDs: fetch every 3 cycles, commit at cycles 3, 6, 9.
    clear_mem();
    alu_lat = 0;
    do_reset("seq");
    repeat (8) tick();
    exp_q = '{16'h000, 16'h001, 16'h002};
    check_fetch("seq");
    check("seq_exec_cnt", 32'(exec_cnt), 3);
    check("seq_exec_c9", 32'(exec_en), 1);
    tick();
    check("seq_pc", 32'(pc), 3);

    // Call/return, then RET on an empty stack, then reset out of HALT.
    clear_mem();
    mem[10'h000] = 16'h8010;  // BRA 0x010
    mem[10'h010] = 16'h8500;  // JMP 0x100
    mem[10'h100] = 16'h8800;  // RET
    mem[10'h011] = 16'h8800;  // RET with empty stack
    do_reset("call");
    run_fetches(3, 50);
    check("call_sp_after_call", 32'(dbg_sp), 1);
    run_until_halt(50, at);
    check("call_halt_cyc", 32'(at), 13);
    exp_q = '{16'h000, 16'h010, 16'h100, 16'h011};
    check_fetch("call");
    check("call_pc", 32'(pc), 32'h011);
    check("call_err", 32'(err), 2);
    check("call_sp", 32'(dbg_sp), 0);
    check("call_exec_cnt", 32'(exec_cnt), 3);
    repeat (3) tick();
    check("halt_frozen_pc", 32'(pc), 32'h011);
    check("halt_frozen_err", 32'(err), 2);
    do_reset("halt_rst");
    run_fetches(2, 20);
    exp_q = '{16'h000, 16'h010};
    check_fetch("halt_rst");

    // Five nested calls against a 4-deep stack.
    clear_mem();
    for (int i = 0; i < 5; i++) mem[i] = 16'h8400 | 16'(i + 1);
    do_reset("ovf");
    run_until_halt(100, at);
    check("ovf_halt_cyc", 32'(at), 16);
    check("ovf_err", 32'(err), 1);
    check("ovf_pc", 32'(pc), 4);
    check("ovf_sp", 32'(dbg_sp), 4);
    check("ovf_exec_cnt", 32'(exec_cnt), 4);

    // Return address wraps past the top of the address space.
    clear_mem();
    mem[10'h000] = 16'h83FF;  // BRA 0x3FF
    mem[10'h3FF] = 16'h8420;  // JMP 0x020, return address 0x000
    mem[10'h020] = 16'h8800;  // RET
    do_reset("wrap_push");
    run_fetches(4, 50);
    exp_q = '{16'h000, 16'h3FF, 16'h020, 16'h000};
    check_fetch("wrap_push");

    // Plain increment wraps from 0x3FF to 0.
    clear_mem();
    mem[10'h000] = 16'h83FF;
    do_reset("wrap_inc");
    run_fetches(3, 50);
    exp_q = '{16'h000, 16'h3FF, 16'h000};
    check_fetch("wrap_inc");

    // alu_done seen only during EXEC must not count: expect the timeout.
    clear_mem();
    mem[0] = 16'h4400;
    alu_early = 1'b1;
    do_reset("early");
    run_until_halt(200, at);
    check("early_halt_cyc", 32'(at), 68);
    check("early_err", 32'(err), 3);
    check("early_exec_cnt", 32'(exec_cnt), 0);
    check("early_starts", 32'(start_cnt), 1);
    alu_early = 1'b0;

    // Reset while stalled in WAIT_ALU aborts with no commit.
    clear_mem();
    mem[0] = 16'h4000;
    alu_lat = 0;
    do_reset("abort");
    repeat (9) tick();
    check("abort_state", 32'(dbg_state), 32'(ST_WAIT_ALU));
    check("abort_exec_cnt", 32'(exec_cnt), 0);
    alu_lat = 2;
    do_reset("abort2");
    run_until_event(50, at);
    check("abort2_cyc", 32'(at), 5);
    tick();
    check("abort2_pc", 32'(pc), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
